cu_sequencer: RTL

Control sequencer directly upstream of the per-class instruction decoders (immediate, register, memory, branch).
- Owns the instruction register and the 4-bit `state` register that feeds every class decoder.
- Classifies the fetched instruction and muxes the selected decoder's NS, controlWord and k_mux onto the datapath.
- Advances state from the selected NS; generates its own FETCH and HALT control words.

---
 rtl/cu_pkg.sv | 53 +++++
 rtl/cu_sequencer_if.sv | 32 +++
 rtl/cu_class_decode.sv | 18 +
 rtl/cu_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit sequencer: state encoding,
// instruction classes and the control-word field layout. Watchdog limit exists only with CU_SEQ_WATCHDOG_EN.
package cu_pkg;

  localparam int CUL    = 35;
  localparam int CW_W   = CUL + 1;
  localparam int NCLASS = 4;

`ifdef CU_SEQ_WATCHDOG_EN
  localparam int MAX_EX   = 8;
  localparam int EX_CNT_W = $clog2(MAX_EX + 1);
`endif

  typedef enum logic [3:0] {
    S_FETCH = 4'b0000,
    S_EX0   = 4'b0001, S_EX1  = 4'b0010, S_EX2  = 4'b0011, S_EX3  = 4'b0100,
    S_EX4   = 4'b0101, S_EX5  = 4'b0110, S_EX6  = 4'b0111, S_EX7  = 4'b1000,
    S_EX8   = 4'b1001, S_EX9  = 4'b1010, S_EX10 = 4'b1011, S_EX11 = 4'b1100,
    S_EX12  = 4'b1101, S_EX13 = 4'b1110,
    S_HALT  = 4'b1111
  } state_e;

  typedef enum logic [1:0] {
    CLS_IMM    = 2'd0,
    CLS_REG    = 2'd1,
    CLS_MEM    = 2'd2,
    CLS_BRANCH = 2'd3
  } class_e;

  // Packed MSB-first: fs occupies [35:31] down to pc_fs at [1:0].
  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;

  localparam cw_t FETCH_CW = '{mem_cs: 2'b01, ir_load: 1'b1, add_tri_sel: 1'b1, default: '0};
  localparam cw_t NOP_CW   = '0;

endpackage

// File: rtl/cu_sequencer_if.sv
// Bundle of everything between the sequencer, instruction memory and the class decoders.
// The master side is the sequencer; the slave side is its environment.
interface cu_sequencer_if;
  import cu_pkg::*;

  logic [31:0]          instr_in;
  logic                 mem_ready;
  logic                 halt_req;
  logic [4*NCLASS-1:0]  ns_bus;
  logic [CW_W*NCLASS-1:0] cw_bus;
  logic [3*NCLASS-1:0]  kmux_bus;

  logic [3:0]           state;
  logic [31:0]          IR;
  logic [CUL:0]         controlWord;
  logic [2:0]           k_mux;
  logic [1:0]           instr_class;
  logic                 instr_done;
  logic                 illegal;
  logic                 halted;
  logic                 wd_trip;

  modport master (
    input  instr_in, mem_ready, halt_req, ns_bus, cw_bus, kmux_bus,
    output state, IR, controlWord, k_mux, instr_class, instr_done, illegal, halted, wd_trip
  );

  modport slave (
    output instr_in, mem_ready, halt_req, ns_bus, cw_bus, kmux_bus,
    input  state, IR, controlWord, k_mux, instr_class, instr_done, illegal, halted, wd_trip
  );
endinterface

// File: rtl/cu_class_decode.sv
// Classifies an instruction from its opcode bits [28:25] into IMM/REG/MEM/BRANCH or illegal.
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [3:0] opc,      // instruction bits [28:25]
  output class_e     cls,
  output logic       illegal
);
  always_comb begin
    cls     = CLS_IMM;
    illegal = 1'b0;
    if (opc[3:1] == 3'b100)      cls = CLS_IMM;
    else if (opc[3:1] == 3'b101) cls = CLS_BRANCH;
    else if (opc[2:0] == 3'b101) cls = CLS_REG;
    else if (opc[2] && !opc[0])  cls = CLS_MEM;
    else                         illegal = 1'b1;
  end
endmodule

// File: rtl/cu_sequencer.sv
// Control sequencer: owns IR and the state register, muxes the selected class decoder onto the datapath.
// Optional execute-cycle watchdog enabled by defining CU_SEQ_WATCHDOG_EN.
module cu_sequencer
  import cu_pkg::*;
(
  input logic            clock,
  input logic            reset,
  cu_sequencer_if.master bus
);
  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  class_e      cls_q, cls_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  dec_opc;
  class_e      dec_cls;
  logic        dec_illegal;
  logic [3:0]  ns_sel, ns_eff;
  cw_t         cw_sel, cw;
  logic [2:0]  kmux_sel, kmux;
  logic        done;

  assign dec_opc = (state_q == S_FETCH) ? bus.instr_in[28:25] : ir_q[28:25];

  cu_class_decode u_dec (.opc(dec_opc), .cls(dec_cls), .illegal(dec_illegal));

  assign ns_sel   = bus.ns_bus[4*int'(cls_q) +: 4];
  assign cw_sel   = cw_t'(bus.cw_bus[CW_W*int'(cls_q) +: CW_W]);
  assign kmux_sel = bus.kmux_bus[3*int'(cls_q) +: 3];
  // A decoder asking for HALT mid-instruction is treated as a normal retire.
  assign ns_eff   = (ns_sel == S_HALT) ? S_FETCH : ns_sel;

`ifdef CU_SEQ_WATCHDOG_EN
  logic [EX_CNT_W-1:0] ex_cnt_q, ex_cnt_d;
  logic                wd_trip_q, wd_trip_d;
  logic                wd_expire;
  assign wd_expire = (ex_cnt_q == EX_CNT_W'(MAX_EX - 1)) && (ns_eff != S_FETCH);
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    cw        = NOP_CW;
    kmux      = 3'b000;
    done      = 1'b0;
`ifdef CU_SEQ_WATCHDOG_EN
    wd_trip_d = wd_trip_q;
`endif
    case (state_q)
      S_FETCH: begin
        cw = FETCH_CW;
        if (bus.mem_ready) begin
          if (bus.halt_req) begin
            state_d = S_HALT;
          end else begin
            ir_d = bus.instr_in;
            if (dec_illegal) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              cls_d   = dec_cls;
              state_d = S_EX0;
            end
          end
        end
      end
      S_HALT: begin
        if (!bus.halt_req && !illegal_q) state_d = S_FETCH;
      end
      default: begin
        cw   = cw_sel;
        kmux = kmux_sel;
        if (ns_eff == S_FETCH) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = state_e'(ns_eff);
        end
`ifdef CU_SEQ_WATCHDOG_EN
        if (wd_expire) begin
          done      = 1'b0;
          wd_trip_d = 1'b1;
          state_d   = S_FETCH;
        end
`endif
      end
    endcase
  end

`ifdef CU_SEQ_WATCHDOG_EN
  always_comb begin
    ex_cnt_d = ex_cnt_q;
    if (state_d == S_FETCH)                            ex_cnt_d = '0;
    else if (state_q != S_FETCH && state_q != S_HALT) ex_cnt_d = ex_cnt_q + 1'b1;
  end
`endif

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      cls_q     <= CLS_IMM;
      illegal_q <= 1'b0;
`ifdef CU_SEQ_WATCHDOG_EN
      ex_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
`ifdef CU_SEQ_WATCHDOG_EN
      ex_cnt_q  <= ex_cnt_d;
      wd_trip_q <= wd_trip_d;
`endif
    end
  end

  assign bus.state       = state_q;
  assign bus.IR          = ir_q;
  assign bus.controlWord = cw;
  assign bus.k_mux       = kmux;
  assign bus.instr_class = cls_q;
  assign bus.instr_done  = done;
  assign bus.illegal     = illegal_q;
  assign bus.halted      = (state_q == S_HALT);
`ifdef CU_SEQ_WATCHDOG_EN
  assign bus.wd_trip     = wd_trip_q;
`else
  assign bus.wd_trip     = 1'b0;
`endif
endmodule
